axis_stall_receiver: RTL and testbench
======================================

// Module: axis_stall_receiver
// PURPOSE
// Parametrised AXI-Stream sink with synthesizable backpressure. Every accepted beat is
// captured and counted, and a per-packet modular checksum is kept. After each beat the
// sink drops s_axis_ready for a programmable stall, which is none, fixed or LFSR-random.
// Used as the consumer endpoint in adder/stream test harnesses to stress upstream handshakes.
// PARAMETERS
// DATA_W      16        stream data width (>=1)
// CNT_W       16        width of beat/packet counters
// STALL_MODE  2         0 = no stall, 1 = fixed STALL_MIN cycles, 2 = random in [STALL_MIN,STALL_MAX]
// STALL_MIN   20        minimum stall cycles (0 allowed)
// STALL_MAX   50        maximum stall cycles (<=255, >=STALL_MIN, else elaboration $error)
// LFSR_SEED   16'hACE1  LFSR reset value (0 is replaced by 16'h0001)
// PORTS
// clk           in   1       rising-edge clock
// rst_n         in   1       asynchronous active-low reset
// s_axis_data   in   DATA_W  stream payload
// s_axis_valid  in   1       source beat valid
// s_axis_last   in   1       last beat of packet
// s_axis_ready  out  1       sink ready
// result        out  DATA_W  last accepted payload (held)
// result_valid  out  1       1-cycle pulse, cycle after each accept
// beat_count    out  CNT_W   accepted beats since reset (wraps)
// pkt_count     out  CNT_W   accepted last-beats since reset (wraps)
// pkt_sum       out  DATA_W  checksum of last completed packet (held)
// pkt_sum_valid out  1       1-cycle pulse, cycle after a last-beat accept
// BEHAVIOUR
// - Reset (async assert, sync release): s_axis_ready=1, result=0, result_valid=0, counts=0,
//   pkt_sum=0, pkt_sum_valid=0, running sum=0, stall counter=0, FSM=READY, LFSR=seed.
// - Accept = s_axis_valid & s_axis_ready at a clk rising edge. Only accepts update state.
// - On accept, next cycle: result<=data, result_valid=1, beat_count+1. If last: pkt_count+1,
//   pkt_sum<=(running_sum+data) mod 2^DATA_W, pkt_sum_valid=1, running_sum<=0. Otherwise
//   running_sum<=running_sum+data.
// - Stall length L per accept: mode0 -> 0; mode1 -> STALL_MIN;
//   mode2 -> STALL_MIN + (lfsr % (STALL_MAX-STALL_MIN+1)), using the LFSR value at the accept edge.
// - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every clock, independent of traffic.
// - FSM READY: ready=1. On accept, if L==0 stay READY (back-to-back beats allowed). Else go to
//   STALL with cnt<=L and ready<=0.
// - FSM STALL: ready=0 and cnt decrements each cycle. When cnt==1, next state is READY with
//   ready<=1. Ready is therefore low for exactly L cycles after the accept edge.
// - s_axis_valid/data while stalled are ignored. No beat is lost or duplicated.
// - Counters wrap from all-ones to 0 silently. Checksum arithmetic is modular.
// - Reset mid-stall: immediate return to READY with ready=1. The partial packet sum is discarded.
// - s_axis_ready is registered and has no combinational path from s_axis_valid.
// TESTING
// T1 mode0: 8 back-to-back beats 1..8, last on 8 -> ready stays 1, beat_count=8,
//    pkt_count=1, pkt_sum=36, result=8.
// T2 mode1 STALL_MIN=3: valid held high with data A5A5 then 5A5A -> ready low exactly 3 cycles
//    between accepts, result=5A5A.
// T3 mode2 MIN=2 MAX=5: 1000 beats -> every stall length is in [2,5], all 4 values occur,
//    scoreboard shows no loss or duplication.
// T4 DATA_W=8: packet FF,FF,03 with last -> pkt_sum=01 (mod 256), pkt_sum_valid pulses once.
// T5 assert rst_n low for 1 cycle mid-stall -> ready=1 and all outputs 0 immediately.
//    Next packet 10,20(last) -> pkt_sum=30.
// T6 valid toggling randomly against random stalls -> accepted sequence equals sent sequence,
//    and ready never rises early.

Source files
------------

// File: rtl/axis_stall_receiver.sv
// AXI-Stream sink with programmable post-beat backpressure (none / fixed / LFSR-random).
// Captures and counts every accepted beat and keeps a modular per-packet checksum.
module axis_stall_receiver #(
  parameter int          DATA_W     = 16,
  parameter int          CNT_W      = 16,
  parameter int          STALL_MODE = 2,
  parameter int          STALL_MIN  = 20,
  parameter int          STALL_MAX  = 50,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_data,
  input  logic              s_axis_valid,
  input  logic              s_axis_last,
  output logic              s_axis_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [DATA_W-1:0] pkt_sum,
  output logic              pkt_sum_valid
);

  if (STALL_MAX > 255 || STALL_MAX < STALL_MIN || STALL_MIN < 0) begin : g_bad_stall
    $error("axis_stall_receiver: need 0 <= STALL_MIN <= STALL_MAX <= 255");
  end

  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          RANGE = (STALL_MAX >= STALL_MIN) ? (STALL_MAX - STALL_MIN + 1) : 1;

  typedef enum logic {ST_READY, ST_STALL} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          stall_len;
  logic [15:0]         lfsr, lfsr_next;
  logic [DATA_W-1:0]   running_sum;
  logic                accept;

  assign accept = s_axis_valid & s_axis_ready;

  // Galois form of x^16+x^14+x^13+x^11, free-running regardless of traffic
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    stall_len = '0;
    case (STALL_MODE)
      1:       stall_len = 8'(STALL_MIN);
      2:       stall_len = 8'(STALL_MIN) + 8'(lfsr % 16'(RANGE));
      default: stall_len = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_READY: begin
        if (accept && stall_len != 8'd0) begin
          state_d = ST_STALL;
          cnt_d   = stall_len;
        end
      end
      ST_STALL: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // Output decode: ready comes straight from the state flop, never from valid
  always_comb begin
    s_axis_ready = 1'b0;
    if (state_q == ST_READY) s_axis_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr          <= SEED;
      result        <= '0;
      result_valid  <= 1'b0;
      beat_count    <= '0;
      pkt_count     <= '0;
      pkt_sum       <= '0;
      pkt_sum_valid <= 1'b0;
      running_sum   <= '0;
    end else begin
      lfsr          <= lfsr_next;
      result_valid  <= accept;
      pkt_sum_valid <= accept & s_axis_last;
      if (accept) begin
        result     <= s_axis_data;
        beat_count <= beat_count + CNT_W'(1);
        if (s_axis_last) begin
          pkt_count   <= pkt_count + CNT_W'(1);
          pkt_sum     <= running_sum + s_axis_data;
          running_sum <= '0;
        end else begin
          running_sum <= running_sum + s_axis_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stall_receiver.sv
// Directed bench for axis_stall_receiver: four instances cover no-stall, fixed-stall,
// random-stall and 8-bit checksum wrap; a reference LFSR predicts each random stall length.
module tb_axis_stall_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // u0: mode 0
  logic [15:0] d0 = '0; logic v0 = 0, l0 = 0, rdy0, rv0, psv0;
  logic [15:0] res0, bc0, pc0, ps0;
  // u1: mode 1, fixed 3
  logic [15:0] d1 = '0; logic v1 = 0, l1 = 0, rdy1, rv1, psv1;
  logic [15:0] res1, bc1, pc1, ps1;
  // u2: mode 2, random 2..5
  logic [15:0] d2 = '0; logic v2 = 0, l2 = 0, rdy2, rv2, psv2;
  logic [15:0] res2, bc2, pc2, ps2;
  // u3: 8-bit data, mode 0
  logic [7:0]  d3 = '0; logic v3 = 0, l3 = 0, rdy3, rv3, psv3;
  logic [7:0]  res3, ps3;
  logic [15:0] bc3, pc3;

  axis_stall_receiver #(.DATA_W(16), .CNT_W(16), .STALL_MODE(0), .STALL_MIN(0), .STALL_MAX(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_axis_data(d0), .s_axis_valid(v0), .s_axis_last(l0),
    .s_axis_ready(rdy0), .result(res0), .result_valid(rv0), .beat_count(bc0),
    .pkt_count(pc0), .pkt_sum(ps0), .pkt_sum_valid(psv0));

  axis_stall_receiver #(.DATA_W(16), .CNT_W(16), .STALL_MODE(1), .STALL_MIN(3), .STALL_MAX(3)) u1 (
    .clk(clk), .rst_n(rst_n), .s_axis_data(d1), .s_axis_valid(v1), .s_axis_last(l1),
    .s_axis_ready(rdy1), .result(res1), .result_valid(rv1), .beat_count(bc1),
    .pkt_count(pc1), .pkt_sum(ps1), .pkt_sum_valid(psv1));

  axis_stall_receiver #(.DATA_W(16), .CNT_W(16), .STALL_MODE(2), .STALL_MIN(2), .STALL_MAX(5),
                        .LFSR_SEED(16'hACE1)) u2 (
    .clk(clk), .rst_n(rst_n), .s_axis_data(d2), .s_axis_valid(v2), .s_axis_last(l2),
    .s_axis_ready(rdy2), .result(res2), .result_valid(rv2), .beat_count(bc2),
    .pkt_count(pc2), .pkt_sum(ps2), .pkt_sum_valid(psv2));

  axis_stall_receiver #(.DATA_W(8), .CNT_W(16), .STALL_MODE(0), .STALL_MIN(0), .STALL_MAX(0)) u3 (
    .clk(clk), .rst_n(rst_n), .s_axis_data(d3), .s_axis_valid(v3), .s_axis_last(l3),
    .s_axis_ready(rdy3), .result(res3), .result_valid(rv3), .beat_count(bc3),
    .pkt_count(pc3), .pkt_sum(ps3), .pkt_sum_valid(psv3));

  // Reference LFSR: x^16+x^14+x^13+x^11, seed ACE1, advancing every clock out of reset
  logic [15:0] m_lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // u2 scoreboard state
  int          u2_beats = 0;
  int          stall_left = 0;
  logic [15:0] u2_sum = '0;

  task automatic test_reset();
    v0 = 0; v1 = 0; v2 = 0; v3 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy0, rdy1, rdy2, rdy3} !== 4'b1111) begin
      errors++; $display("FAIL reset_ready got=%b exp=1111", {rdy0, rdy1, rdy2, rdy3});
    end
    checks++;
    if ({rv0, rv1, rv2, rv3, psv0, psv1, psv2, psv3} !== 8'h00) begin
      errors++; $display("FAIL reset_pulses got=%b exp=00000000", {rv0, rv1, rv2, rv3, psv0, psv1, psv2, psv3});
    end
    checks++;
    if ((res0 | res1 | res2 | bc0 | bc1 | bc2 | pc0 | pc1 | pc2 | ps0 | ps1 | ps2) !== 16'h0) begin
      errors++; $display("FAIL reset_regs16 got=%h exp=0000", res0 | res1 | res2 | bc0 | bc2 | pc2 | ps2);
    end
    checks++;
    if ((res3 | ps3) !== 8'h0 || (bc3 | pc3) !== 16'h0) begin
      errors++; $display("FAIL reset_regs8 got=%h/%h exp=0", res3 | ps3, bc3 | pc3);
    end
    rst_n = 1'b1;
    u2_beats = 0; stall_left = 0; u2_sum = '0;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      v0 = 1; d0 = 16'(i); l0 = (i == 8);
      checks++;
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, rdy0); end
      @(posedge clk); #1;
      checks++;
      if (rv0 !== 1'b1 || res0 !== 16'(i)) begin
        errors++; $display("FAIL b2b_result beat=%0d got=%h/%b exp=%h/1", i, res0, rv0, 16'(i));
      end
    end
    v0 = 0; l0 = 0;
    checks++;
    if (bc0 !== 16'd8 || pc0 !== 16'd1) begin
      errors++; $display("FAIL b2b_counts got=%0d/%0d exp=8/1", bc0, pc0);
    end
    checks++;
    if (ps0 !== 16'd36 || psv0 !== 1'b1) begin
      errors++; $display("FAIL b2b_sum got=%0d/%b exp=36/1", ps0, psv0);
    end
    @(posedge clk); #1;
    checks++;
    if (rv0 !== 1'b0 || psv0 !== 1'b0 || res0 !== 16'd8) begin
      errors++; $display("FAIL b2b_idle got=%b/%b/%h exp=0/0/0008", rv0, psv0, res0);
    end
  endtask

  task automatic test_fixed_stall();
    int low;
    v1 = 1; d1 = 16'hA5A5;
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL fix_ready0 got=%b exp=1", rdy1); end
    @(posedge clk); #1;
    d1 = 16'h5A5A;
    low = 0;
    while (!rdy1 && low < 10) begin low++; @(posedge clk); #1; end
    checks++;
    if (low !== 3) begin errors++; $display("FAIL fix_stall1 got=%0d exp=3", low); end
    checks++;
    if (res1 !== 16'hA5A5 || bc1 !== 16'd1) begin
      errors++; $display("FAIL fix_hold got=%h/%0d exp=a5a5/1", res1, bc1);
    end
    @(posedge clk); #1;
    v1 = 0;
    checks++;
    if (res1 !== 16'h5A5A || rv1 !== 1'b1 || bc1 !== 16'd2) begin
      errors++; $display("FAIL fix_result got=%h/%b/%0d exp=5a5a/1/2", res1, rv1, bc1);
    end
    low = 0;
    while (!rdy1 && low < 10) begin low++; @(posedge clk); #1; end
    checks++;
    if (low !== 3) begin errors++; $display("FAIL fix_stall2 got=%0d exp=3", low); end
  endtask

  // u2 traffic: constant or random valid; every cycle ready is checked against the
  // stall length predicted from the reference LFSR at the accept edge.
  task automatic test_random_traffic(input int n, input bit rnd);
    int sent = 0, cyc = 0, run = 0, bad_len = 0;
    int hist[4] = '{default: 0};
    logic [15:0] cap, sum;
    logic exp_rdy, acc;
    d2 = rnd ? 16'($urandom) : 16'd1;
    l2 = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    while (sent < n && cyc < n * 50) begin
      cyc++;
      v2 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_rdy = (stall_left == 0);
      checks++;
      if (rdy2 !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, rdy2, exp_rdy);
      end
      if (!rdy2) run++;
      else if (run > 0) begin
        if (run >= 2 && run <= 5) hist[run-2]++;
        else bad_len++;
        run = 0;
      end
      cap = m_lfsr;
      acc = v2 && rdy2;
      @(posedge clk); #1;
      if (acc) begin
        checks++;
        if (rv2 !== 1'b1 || res2 !== d2 || bc2 !== 16'(u2_beats + 1)) begin
          errors++;
          $display("FAIL rnd_beat n=%0d got=%h/%b/%0d exp=%h/1/%0d", sent, res2, rv2, bc2, d2, u2_beats + 1);
        end
        sum = u2_sum + d2;
        checks++;
        if (l2) begin
          if (ps2 !== sum || psv2 !== 1'b1) begin
            errors++; $display("FAIL rnd_pkt got=%h/%b exp=%h/1", ps2, psv2, sum);
          end
          u2_sum = '0;
        end else begin
          if (psv2 !== 1'b0) begin errors++; $display("FAIL rnd_pktv got=%b exp=0", psv2); end
          u2_sum = sum;
        end
        u2_beats++; sent++;
        stall_left = 2 + int'(cap % 16'd4);
        d2 = rnd ? 16'($urandom) : 16'(sent + 1);
        l2 = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else begin
        if (stall_left > 0) stall_left--;
        checks++;
        if (rv2 !== 1'b0) begin errors++; $display("FAIL rnd_rv got=%b exp=0", rv2); end
      end
    end
    v2 = 0; l2 = 0;
    checks++;
    if (sent != n) begin errors++; $display("FAIL rnd_timeout got=%0d exp=%0d", sent, n); end
    checks++;
    if (bad_len != 0) begin errors++; $display("FAIL rnd_len_range got=%0d exp=0", bad_len); end
    if (!rnd) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (hist[k] == 0) begin errors++; $display("FAIL rnd_len_seen len=%0d got=0 exp>0", k + 2); end
      end
    end
  endtask

  task automatic test_checksum_wrap();
    logic [7:0] dat [3] = '{8'hFF, 8'hFF, 8'h03};
    int pulses = 0;
    for (int i = 0; i < 7; i++) begin
      v3 = (i < 3); d3 = (i < 3) ? dat[i] : 8'h00; l3 = (i == 2);
      @(posedge clk); #1;
      if (psv3) pulses++;
      if (i == 2) begin
        checks++;
        if (ps3 !== 8'h01 || psv3 !== 1'b1 || res3 !== 8'h03) begin
          errors++; $display("FAIL wrap_sum got=%h/%b/%h exp=01/1/03", ps3, psv3, res3);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL wrap_pulses got=%0d exp=1", pulses); end
    checks++;
    if (bc3 !== 16'd3 || pc3 !== 16'd1) begin
      errors++; $display("FAIL wrap_counts got=%0d/%0d exp=3/1", bc3, pc3);
    end
  endtask

  task automatic test_reset_mid_stall();
    int k = 0;
    v1 = 1; d1 = 16'h0007; l1 = 0;
    @(posedge clk); #1;
    v1 = 0;
    checks++;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL mid_stalled got=%b exp=0", rdy1); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || psv1 !== 1'b0) begin
      errors++; $display("FAIL mid_ready got=%b/%b/%b exp=1/0/0", rdy1, rv1, psv1);
    end
    checks++;
    if ((res1 | bc1 | pc1 | ps1) !== 16'h0) begin
      errors++; $display("FAIL mid_clear got=%h/%h/%h/%h exp=0", res1, bc1, pc1, ps1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    u2_beats = 0; stall_left = 0; u2_sum = '0;
    v1 = 1; d1 = 16'h0010;
    @(posedge clk); #1;
    d1 = 16'h0020; l1 = 1;
    while (!rdy1 && k < 10) begin k++; @(posedge clk); #1; end
    @(posedge clk); #1;
    v1 = 0; l1 = 0;
    checks++;
    if (ps1 !== 16'h0030 || psv1 !== 1'b1 || pc1 !== 16'd1 || bc1 !== 16'd2) begin
      errors++; $display("FAIL mid_pkt got=%h/%b/%0d/%0d exp=0030/1/1/2", ps1, psv1, pc1, bc1);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_fixed_stall();
    test_random_traffic(1000, 1'b0);
    test_checksum_wrap();
    test_reset_mid_stall();
    test_random_traffic(200, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
